// File: rtl/exp_compare_swap.sv
// exp_compare_swap
// ----------------
// Front end of a binary32 adder: unpacks two operands, decides which one has
// the larger magnitude, swaps them so the larger one comes out on the "large"
// side, and reports the exponent difference used to right-shift the smaller
// mantissa. Two pipeline stages with valid/ready flow control.
//
// Optional feature (macro EXP_DIFF_SAT_EN): when defined, o_diff_value is
// clamped to SIZE_DATA-1 because any larger shift empties the mantissa anyway.
// When undefined, the raw 8-bit difference is passed through.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_operand_a/b       binary32 operands
//   i_valid / o_ready   input handshake
//   o_valid / i_ready   output handshake
//   o_exp_max           larger effective exponent
//   o_diff_value        exponent difference (large - small), SIZE_SHIFT bits
//   o_mant_large        mantissa of the larger operand
//   o_mant_small        mantissa of the smaller operand (still unshifted)
//   o_sign_large/small  signs of the larger / smaller operand
//   o_swap              1 when B is the larger operand
//   o_special           1 when either operand has exponent 0xFF
`timescale 1ns/1ps

module exp_compare_swap #(
    parameter int SIZE_SHIFT = 8,
    parameter int SIZE_DATA  = 28
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [31:0]           i_operand_a,
    input  logic [31:0]           i_operand_b,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [7:0]            o_exp_max,
    output logic [SIZE_SHIFT-1:0] o_diff_value,
    output logic [SIZE_DATA-1:0]  o_mant_large,
    output logic [SIZE_DATA-1:0]  o_mant_small,
    output logic                  o_sign_large,
    output logic                  o_sign_small,
    output logic                  o_swap,
    output logic                  o_special
);

    // Handshake: a stage transfers when its valid and its ready are both high
    // on a rising edge; otherwise it holds data and valid. Ready never looks
    // at the upstream valid, so there is no i_valid -> o_ready path.

    // ---------------- unpack and compare (feeds stage 1) ----------------
    logic [7:0]           exp_a_raw, exp_b_raw;
    logic                 hid_a, hid_b;
    logic [7:0]           eff_a, eff_b;
    logic [31:0]          key_a, key_b;
    logic                 swap_in;
    logic                 special_in;
    logic [SIZE_DATA-1:0] mant_a_in, mant_b_in;

    always_comb begin
        exp_a_raw  = i_operand_a[30:23];
        exp_b_raw  = i_operand_b[30:23];
        hid_a      = |exp_a_raw;
        hid_b      = |exp_b_raw;
        // Denormals behave as exponent 1 without the hidden bit.
        eff_a      = hid_a ? exp_a_raw : 8'd1;
        eff_b      = hid_b ? exp_b_raw : 8'd1;
        key_a      = {eff_a, hid_a, i_operand_a[22:0]};
        key_b      = {eff_b, hid_b, i_operand_b[22:0]};
        // Strict compare: a full tie keeps A on the large side.
        swap_in    = key_b > key_a;
        special_in = (&exp_a_raw) | (&exp_b_raw);
        mant_a_in  = SIZE_DATA'({1'b0, hid_a, i_operand_a[22:0], 3'b000});
        mant_b_in  = SIZE_DATA'({1'b0, hid_b, i_operand_b[22:0], 3'b000});
    end

    // ---------------- flow control ----------------
    logic v1, v2;
    logic run;       // low during reset and until the first edge after it
    logic advance2;

    always_comb begin
        advance2 = !v2 || i_ready;
        o_ready  = run && (!v1 || advance2);
        o_valid  = v2;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) run <= 1'b0;
        else          run <= 1'b1;
    end

    // ---------------- stage 1 ----------------
    logic [7:0]           s1_exp_a, s1_exp_b;
    logic [SIZE_DATA-1:0] s1_mant_a, s1_mant_b;
    logic                 s1_sign_a, s1_sign_b, s1_swap, s1_special;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1         <= 1'b0;
            s1_exp_a   <= '0;
            s1_exp_b   <= '0;
            s1_mant_a  <= '0;
            s1_mant_b  <= '0;
            s1_sign_a  <= 1'b0;
            s1_sign_b  <= 1'b0;
            s1_swap    <= 1'b0;
            s1_special <= 1'b0;
        end else if (o_ready) begin
            v1 <= i_valid;
            if (i_valid) begin
                s1_exp_a   <= eff_a;
                s1_exp_b   <= eff_b;
                s1_mant_a  <= mant_a_in;
                s1_mant_b  <= mant_b_in;
                s1_sign_a  <= i_operand_a[31];
                s1_sign_b  <= i_operand_b[31];
                s1_swap    <= swap_in;
                s1_special <= special_in;
            end
        end
    end

    // ---------------- swap and difference (feeds stage 2) ----------------
    logic [7:0]            exp_large, exp_small, diff_raw, diff_sel;
    logic [SIZE_SHIFT-1:0] diff_in;

`ifdef EXP_DIFF_SAT_EN
    localparam logic [7:0] DIFF_SAT = 8'(SIZE_DATA - 1);
`endif

    always_comb begin
        exp_large = s1_swap ? s1_exp_b : s1_exp_a;
        exp_small = s1_swap ? s1_exp_a : s1_exp_b;
        // The larger key always has the larger-or-equal exponent, so this
        // subtraction cannot wrap.
        diff_raw  = exp_large - exp_small;
`ifdef EXP_DIFF_SAT_EN
        diff_sel  = (diff_raw >= DIFF_SAT) ? DIFF_SAT : diff_raw;
`else
        diff_sel  = diff_raw;
`endif
        diff_in   = SIZE_SHIFT'(diff_sel);
    end

    // ---------------- stage 2 (output registers) ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v2           <= 1'b0;
            o_exp_max    <= '0;
            o_diff_value <= '0;
            o_mant_large <= '0;
            o_mant_small <= '0;
            o_sign_large <= 1'b0;
            o_sign_small <= 1'b0;
            o_swap       <= 1'b0;
            o_special    <= 1'b0;
        end else if (advance2) begin
            v2 <= v1;
            if (v1) begin
                o_exp_max    <= exp_large;
                o_diff_value <= diff_in;
                o_mant_large <= s1_swap ? s1_mant_b : s1_mant_a;
                o_mant_small <= s1_swap ? s1_mant_a : s1_mant_b;
                o_sign_large <= s1_swap ? s1_sign_b : s1_sign_a;
                o_sign_small <= s1_swap ? s1_sign_a : s1_sign_b;
                o_swap       <= s1_swap;
                o_special    <= s1_special;
            end
        end
    end

endmodule

// File: tb/tb_exp_compare_swap.sv
`timescale 1ns/1ps

module tb_exp_compare_swap;

  localparam int SIZE_SHIFT = 8;
  localparam int SIZE_DATA  = 28;

  typedef struct packed {
    logic [7:0]  exp_max;
    logic [7:0]  diff;
    logic [27:0] mant_large;
    logic [27:0] mant_small;
    logic        sign_large;
    logic        sign_small;
    logic        swap;
    logic        special;
  } res_t;

  localparam int RES_W = $bits(res_t);

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    res_t        exp;
  } vec_t;

`ifdef EXP_DIFF_SAT_EN
  localparam logic [7:0] D_7F = 8'h1B;
  localparam logic [7:0] D_80 = 8'h1B;
  localparam logic [7:0] D_FE = 8'h1B;
`else
  localparam logic [7:0] D_7F = 8'h7F;
  localparam logic [7:0] D_80 = 8'h80;
  localparam logic [7:0] D_FE = 8'hFE;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic                  clk;
  logic                  i_rst_n;
  logic [31:0]           i_operand_a, i_operand_b;
  logic                  i_valid, o_ready, o_valid, i_ready;
  logic [7:0]            o_exp_max;
  logic [SIZE_SHIFT-1:0] o_diff_value;
  logic [SIZE_DATA-1:0]  o_mant_large, o_mant_small;
  logic                  o_sign_large, o_sign_small, o_swap, o_special;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_compare_swap #(.SIZE_SHIFT(SIZE_SHIFT), .SIZE_DATA(SIZE_DATA)) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_operand_a  (i_operand_a),
    .i_operand_b  (i_operand_b),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_exp_max    (o_exp_max),
    .o_diff_value (o_diff_value),
    .o_mant_large (o_mant_large),
    .o_mant_small (o_mant_small),
    .o_sign_large (o_sign_large),
    .o_sign_small (o_sign_small),
    .o_swap       (o_swap),
    .o_special    (o_special)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [RES_W-1:0] exp_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic res_t cur();
    return {o_exp_max, o_diff_value, o_mant_large, o_mant_small,
            o_sign_large, o_sign_small, o_swap, o_special};
  endfunction

  // Reference model: for non-negative magnitudes the bit pattern [30:0]
  // orders exactly like the value, so the compare is done on that.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic [7:0]  ea, eb, d;
    logic [27:0] ma, mb;
    logic        sw;
    ea = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    ma = 28'({a[22:0], 3'b000});
    mb = 28'({b[22:0], 3'b000});
    if (a[30:23] != 8'd0) ma = ma + 28'h4000000;
    if (b[30:23] != 8'd0) mb = mb + 28'h4000000;
    sw = (b[30:0] > a[30:0]);
    d  = sw ? (eb - ea) : (ea - eb);
`ifdef EXP_DIFF_SAT_EN
    if (d >= 8'd27) d = 8'd27;
`endif
    r.exp_max    = sw ? eb : ea;
    r.diff       = d;
    r.mant_large = sw ? mb : ma;
    r.mant_small = sw ? ma : mb;
    r.sign_large = sw ? b[31] : a[31];
    r.sign_small = sw ? a[31] : b[31];
    r.swap       = sw;
    r.special    = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    return r;
  endfunction

  task automatic add_vec(input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] em, input logic [7:0] d,
                         input logic [27:0] ml, input logic [27:0] ms,
                         input logic sl, input logic ss, input logic sw, input logic sp);
    vec_t v;
    v.a = a;
    v.b = b;
    v.exp.exp_max    = em;
    v.exp.diff       = d;
    v.exp.mant_large = ml;
    v.exp.mant_small = ms;
    v.exp.sign_large = sl;
    v.exp.sign_small = ss;
    v.exp.swap       = sw;
    v.exp.special    = sp;
    vecs.push_back(v);
  endtask

  // ---------------- monitor: pop and compare on each output transfer ----------------
  always begin
    @(negedge clk);
    #4;
    if (i_rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", cur());
      end else begin
        check("result", cur(), exp_q.pop_front());
        n_out++;
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b, input res_t e);
    int   budget;
    logic acc;
    budget = 0;
    acc = 1'b0;
    i_valid = 1'b1;
    i_operand_a = a;
    i_operand_b = b;
    while (!acc && budget < 200) begin
      #4;
      acc = o_ready;
      if (acc) exp_q.push_back(e);
      @(negedge clk);
      budget++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
    end
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (exp_q.size() != 0 && b < 100);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  // ---------------- main test ----------------
  initial begin
    res_t snap;
    int   c0, n0;
    logic [31:0] ra, rb;

    add_vec(32'h40400000, 32'h3F800000, 8'h80, 8'h01, 28'h6000000, 28'h4000000, 0, 0, 0, 0);
    add_vec(32'h3F800000, 32'h3FC00000, 8'h7F, 8'h00, 28'h6000000, 28'h4000000, 0, 0, 1, 0);
    add_vec(32'h00000001, 32'h00800000, 8'h01, 8'h00, 28'h4000000, 28'h0000008, 0, 0, 1, 0);
    add_vec(32'h7F000000, 32'h3F800000, 8'hFE, D_7F,  28'h4000000, 28'h4000000, 0, 0, 0, 0);
    add_vec(32'h7F800000, 32'h3F800000, 8'hFF, D_80,  28'h4000000, 28'h4000000, 0, 0, 0, 1);
    add_vec(32'hC0000000, 32'h40400000, 8'h80, 8'h00, 28'h6000000, 28'h4000000, 0, 1, 1, 0);
    add_vec(32'h80000000, 32'h00000000, 8'h01, 8'h00, 28'h0000000, 28'h0000000, 1, 0, 0, 0);
    add_vec(32'h3F800000, 32'h3F800000, 8'h7F, 8'h00, 28'h4000000, 28'h4000000, 0, 0, 0, 0);
    add_vec(32'h00000000, 32'h7FC00000, 8'hFF, D_FE,  28'h6000000, 28'h0000000, 0, 0, 1, 1);

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_operand_a = '0;
    i_operand_b = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_outputs", {o_valid, o_ready, cur()}, 0);
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", o_ready, 1);
    @(negedge clk);

    // Table vectors, back to back: one accept per cycle.
    c0 = cyc;
    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].exp);
    check("throughput", cyc - c0, vecs.size());
    drain();

    // Latency: valid appears on the second edge after the accept edge.
    send(vecs[0].a, vecs[0].b, vecs[0].exp);
    #4;
    check("latency_edge1", o_valid, 0);
    @(negedge clk);
    #1;
    check("latency_edge2", o_valid, 1);
    drain();

    // Stall with three back-to-back pairs.
    n0 = n_out;
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_operand_a = vecs[0].a;
    i_operand_b = vecs[0].b;
    #4;
    check("stall_accept1", o_ready, 1);
    exp_q.push_back(vecs[0].exp);
    @(negedge clk);
    i_operand_a = vecs[1].a;
    i_operand_b = vecs[1].b;
    #4;
    check("stall_accept2", o_ready, 1);
    exp_q.push_back(vecs[1].exp);
    @(negedge clk);
    i_operand_a = vecs[2].a;
    i_operand_b = vecs[2].b;
    #4;
    check("stall_ready_low", o_ready, 0);
    check("stall_valid", o_valid, 1);
    snap = cur();
    check("stall_head", snap, vecs[0].exp);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      #4;
      check("stall_hold", cur(), snap);
      check("stall_ready_held_low", o_ready, 0);
      @(negedge clk);
    end
    i_ready = 1'b1;
    #4;
    check("stall_release_ready", o_ready, 1);
    exp_q.push_back(vecs[2].exp);
    @(negedge clk);
    i_valid = 1'b0;
    drain();
    check("stall_count", n_out - n0, 3);

    // Reset with two items in flight.
    i_ready = 1'b0;
    send(vecs[3].a, vecs[3].b, vecs[3].exp);
    send(vecs[4].a, vecs[4].b, vecs[4].exp);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_ready", o_ready, 0);
    check("midrst_outputs", cur(), 0);
    exp_q.delete();
    @(negedge clk);
    i_ready = 1'b1;
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready_after_release", o_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #4;
      check("midrst_no_stale", o_valid, 0);
    end
    @(negedge clk);

    // Random operands with random downstream back-pressure.
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          ra = $urandom();
          rb = $urandom();
          if ($urandom_range(0, 3) == 0) ra[30:23] = 8'($urandom_range(0, 2));
          if ($urandom_range(0, 3) == 0) rb[30:23] = 8'($urandom_range(0, 2));
          if ($urandom_range(0, 4) == 0) rb[30:0] = ra[30:0] ^ 31'($urandom_range(0, 1));
          send(ra, rb, model(ra, rb));
        end
      end
      begin
        for (int k = 0; k < 60; k++) begin
          i_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        i_ready = 1'b1;
      end
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
